// File: rtl/serial_sub4_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and default width.
package serial_sub4_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_sub.sv
// Single-bit combinational full subtractor: d = a - b - b_in, b_out = borrow.
module full_sub (
    output logic b_out,
    output logic d,
    input  logic a,
    input  logic b,
    input  logic b_in
);

    assign d     = a ^ b ^ b_in;
    assign b_out = (~a & b) | (~a & b_in) | (b & b_in);

endmodule

// File: rtl/serial_sub4.sv
// Bit-serial two's-complement subtractor: one full-subtractor cell, LSB first,
// WIDTH cycles per operation behind a start/ready/done handshake.
module serial_sub4
    import serial_sub4_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             b_out
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    // The final difference bit goes straight to d, so only WIDTH-1 bits are ever held.
    logic [WIDTH-2:0] d_sh_q, d_sh_d;
    logic             brw_q, brw_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             b_out_q, b_out_d;

    logic             diff;
    logic             bnew;
    logic             last_bit;
    logic [WIDTH-1:0] d_cat;

    full_sub u_full_sub (
        .b_out (bnew),
        .d     (diff),
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .b_in  (brw_q)
    );

    assign last_bit = (cnt_q == CW'(WIDTH - 1));
    assign d_cat    = {diff, d_sh_q};

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start)    state_d = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_d = ST_DONE;
            ST_DONE:                state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready = (state_q == ST_IDLE);
        busy  = (state_q == ST_SHIFT);
        done  = (state_q == ST_DONE);
    end

    // Datapath next-state; d/b_out load on the last shift so they appear with done.
    always_comb begin
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        d_sh_d  = d_sh_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        b_out_d = b_out_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d = a;
                    b_sh_d = b;
                    brw_d  = b_in;
                    cnt_d  = '0;
                end
            end
            ST_SHIFT: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                d_sh_d = d_cat[WIDTH-1:1];
                brw_d  = bnew;
                cnt_d  = cnt_q + CW'(1);
                if (last_bit) begin
                    d_d     = d_cat;
                    b_out_d = bnew;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            d_sh_q  <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            d_q     <= '0;
            b_out_q <= 1'b0;
        end else begin
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            d_sh_q  <= d_sh_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            b_out_q <= b_out_d;
        end
    end

    assign d     = d_q;
    assign b_out = b_out_q;

endmodule

// File: tb/tb_serial_sub4.sv
// Self-checking bench for serial_sub4: directed vector table, handshake corner
// cases, and an exhaustive back-to-back sweep against an arithmetic model.
module tb_serial_sub4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] a, b;
    logic       b_in;
    logic       ready, busy, done;
    logic [3:0] d;
    logic       b_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bi;
        logic [3:0] d;
        logic       bo;
    } vec_t;

    vec_t vecs[8];

    serial_sub4 #(.WIDTH(4), .CW(6)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .b_in  (b_in),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .b_out (b_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Starts one operation from a negedge where ready=1; returns at the negedge
    // where done is seen (or after a bounded wait), with lat in cycles.
    task automatic do_op(input logic [3:0] ta, input logic [3:0] tb_v, input logic tbi,
                         output logic [3:0] od, output logic ob, output int lat);
        a = ta; b = tb_v; b_in = tbi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        od = d;
        ob = b_out;
    endtask

    initial begin
        logic [3:0] got_d;
        logic       got_bo;
        logic [3:0] ea, eb;
        logic       ebi;
        logic [4:0] m;
        int         lat;
        int         ndone;

        vecs[0] = '{4'h9, 4'h3, 1'b0, 4'h6, 1'b0};
        vecs[1] = '{4'h3, 4'h9, 1'b0, 4'hA, 1'b1};
        vecs[2] = '{4'h0, 4'h0, 1'b1, 4'hF, 1'b1};
        vecs[3] = '{4'hF, 4'hF, 1'b0, 4'h0, 1'b0};
        vecs[4] = '{4'h5, 4'h5, 1'b1, 4'hF, 1'b1};
        vecs[5] = '{4'h8, 4'h1, 1'b0, 4'h7, 1'b0};
        vecs[6] = '{4'h7, 4'h0, 1'b1, 4'h6, 1'b0};
        vecs[7] = '{4'h2, 4'h7, 1'b1, 4'hA, 1'b1};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", {ready, busy, done, d, b_out}, {1'b1, 1'b0, 1'b0, 4'h0, 1'b0});
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors, one at a time
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].bi, got_d, got_bo, lat);
            check($sformatf("vec%0d_d", i), got_d, vecs[i].d);
            check($sformatf("vec%0d_bout", i), got_bo, vecs[i].bo);
            check($sformatf("vec%0d_latency", i), lat, 5);
            @(negedge clk);
            check($sformatf("vec%0d_ready_after", i), {ready, done}, 2'b10);
        end

        // Start while busy is ignored; exactly one done with the first result
        a = 4'h9; b = 4'h3; b_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_in_shift", {ready, busy}, 2'b01);
        @(negedge clk);
        a = 4'h1; b = 4'h1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            if (done) begin
                ndone++;
                check("done_cycle_rdy_busy", {ready, busy}, 2'b00);
                check("ignored_start_d", {d, b_out}, {4'h6, 1'b0});
            end
            @(negedge clk);
        end
        check("ignored_start_done_count", ndone, 1);

        // Reset during SHIFT aborts without a done pulse
        a = 4'h7; b = 4'h2; b_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int k = 0; k < 2; k++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        if (done) ndone++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_outputs", {ready, busy, done, d, b_out}, {1'b1, 1'b0, 1'b0, 4'h0, 1'b0});
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        do_op(4'h5, 4'h5, 1'b0, got_d, got_bo, lat);
        check("after_abort_result", {got_d, got_bo}, {4'h0, 1'b0});
        check("after_abort_latency", lat, 5);
        @(negedge clk);

        // start and rst together: rst wins
        a = 4'h9; b = 4'h3; start = 1'b1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_beats_start", {ready, busy}, 2'b10);
        ndone = 0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("rst_beats_start_idle", ndone, 0);

        // Exhaustive sweep with start held high; inputs scrambled mid-operation
        start = 1'b1;
        for (int i = 0; i < 512; i++) begin
            ea = i[8:5]; eb = i[4:1]; ebi = i[0];
            m = {1'b0, ea} - {1'b0, eb} - {4'b0, ebi};
            a = ea; b = eb; b_in = ebi;
            check("b2b_ready", ready, 1'b1);
            @(negedge clk);
            a = ~ea; b = ~eb; b_in = ~ebi;
            repeat (4) @(negedge clk);
            check("b2b_done", done, 1'b1);
            check($sformatf("exh_%0h_%0h_%0d", ea, eb, ebi), {d, b_out}, {m[3:0], m[4]});
            @(negedge clk);
        end
        start = 1'b0;
        repeat (8) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
